// File: rtl/rv32_pkg.sv
// Shared RV32 decode constants, M-extension state encoding and operand-sign helpers.
package rv32_pkg;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic rs1_signed(input logic [2:0] f3);
    return f3 inside {F3_MUL, F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
  endfunction

  function automatic logic rs2_signed(input logic [2:0] f3);
    return f3 inside {F3_MUL, F3_MULH, F3_DIV, F3_REM};
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// EX-stage handshake between the pipeline and the multiply/divide unit.
interface muldiv_unit_if #(parameter int XLEN = 32);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            flush;
  logic            stall;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output start, funct3, rs1, rs2, flush,
                  input  stall, busy, done, result);
  modport slave  (input  start, funct3, rs1, rs2, flush,
                  output stall, busy, done, result);
endinterface

// File: rtl/muldiv_core.sv
// Datapath for the iterative multiply/divide: shift-add accumulator and restoring divider.
module muldiv_core #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic              is_div,
  input  logic [XLEN-1:0]   a_mag,
  input  logic [XLEN-1:0]   b_mag,
  output logic [2*XLEN-1:0] product,
  output logic [XLEN-1:0]   quotient,
  output logic [XLEN-1:0]   remainder
);

  // acc low half holds the multiplier (mul) or the dividend/quotient (div)
  logic [2*XLEN-1:0] acc;
  logic [XLEN:0]     prem;
  logic [XLEN-1:0]   opnd;

  logic [XLEN:0]     mul_sum;
  logic [XLEN+1:0]   div_shift;
  logic [XLEN+1:0]   div_trial;

  // One iteration of either shift-add or restoring subtract
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    div_shift = {prem, acc[XLEN-1]};
    div_trial = div_shift - {2'b00, opnd};
  end

  // Datapath registers: load operands, then iterate while step is high
  always_ff @(posedge clk) begin
    if (rst) begin
      acc  <= '0;
      prem <= '0;
      opnd <= '0;
    end else if (load) begin
      acc  <= {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
      opnd <= is_div ? b_mag : a_mag;
      prem <= '0;
    end else if (step) begin
      if (is_div) begin
        if (!div_trial[XLEN+1]) begin
          prem <= div_trial[XLEN:0];
          acc  <= {acc[2*XLEN-1:XLEN], acc[XLEN-2:0], 1'b1};
        end else begin
          prem <= div_shift[XLEN:0];
          acc  <= {acc[2*XLEN-1:XLEN], acc[XLEN-2:0], 1'b0};
        end
      end else begin
        acc <= {mul_sum, acc[XLEN-1:1]};
      end
    end
  end

  assign product   = acc;
  assign quotient  = acc[XLEN-1:0];
  assign remainder = prem[XLEN-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: FSM, iteration counter, sign fix-up and result register.
module muldiv_unit
  import rv32_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic           clk,
  input  logic           rst,
  muldiv_unit_if.slave   bus
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state, state_nx;
  logic [2:0]        f3_q;
  logic [CW-1:0]     count;
  logic              a_neg, b_neg;
  logic [XLEN-1:0]   result_q;

  logic              accept, special, div_zero, div_ovf;
  logic              a_neg_in, b_neg_in, stall;
  logic [XLEN-1:0]   a_mag_in, b_mag_in, special_val, fix_val;
  logic [2*XLEN-1:0] product, prod_s;
  logic [XLEN-1:0]   quotient, remainder, quot_s, rem_s;

  // Operand decode, special-case detection and sign fix-up
  always_comb begin
    accept   = (state == IDLE) && bus.start && !bus.flush;
    a_neg_in = rs1_signed(bus.funct3) && bus.rs1[XLEN-1];
    b_neg_in = rs2_signed(bus.funct3) && bus.rs2[XLEN-1];
    a_mag_in = a_neg_in ? -bus.rs1 : bus.rs1;
    b_mag_in = b_neg_in ? -bus.rs2 : bus.rs2;
    div_zero = bus.funct3[2] && (bus.rs2 == '0);
    div_ovf  = ((bus.funct3 == F3_DIV) || (bus.funct3 == F3_REM)) &&
               (bus.rs1 == MIN_INT) && (bus.rs2 == '1);
    special  = div_zero || div_ovf;
    if (div_zero) special_val = bus.funct3[1] ? bus.rs1 : '1;
    else          special_val = bus.funct3[1] ? '0 : MIN_INT;

    prod_s = (a_neg ^ b_neg) ? -product  : product;
    quot_s = (a_neg ^ b_neg) ? -quotient : quotient;
    rem_s  = a_neg ? -remainder : remainder;
    unique case (f3_q)
      F3_MUL:                       fix_val = prod_s[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: fix_val = prod_s[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              fix_val = quot_s;
      default:                      fix_val = rem_s;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state and pipeline control outputs; flush overrides every transition
  always_comb begin
    state_nx = state;
    stall    = 1'b0;
    unique case (state)
      IDLE: if (accept) begin
              stall    = 1'b1;
              state_nx = special ? DONE : CALC;
            end
      CALC: begin
              stall = 1'b1;
              if (count == '0) state_nx = FIX;
            end
      FIX:  begin
              stall    = 1'b1;
              state_nx = DONE;
            end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (bus.flush) state_nx = IDLE;
  end

  // Operation context, iteration counter and result register
  always_ff @(posedge clk) begin
    if (rst) begin
      f3_q     <= '0;
      count    <= '0;
      a_neg    <= 1'b0;
      b_neg    <= 1'b0;
      result_q <= '0;
    end else if (accept) begin
      f3_q  <= bus.funct3;
      count <= CW'(XLEN - 1);
      a_neg <= a_neg_in;
      b_neg <= b_neg_in;
      if (special) result_q <= special_val;
    end else if (state == CALC) begin
      count <= count - CW'(1);
    end else if ((state == FIX) && !bus.flush) begin
      result_q <= fix_val;
    end
  end

  muldiv_core #(.XLEN(XLEN)) u_core (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .step      (state == CALC),
    .is_div    (accept ? bus.funct3[2] : f3_q[2]),
    .a_mag     (a_mag_in),
    .b_mag     (b_mag_in),
    .product   (product),
    .quotient  (quotient),
    .remainder (remainder)
  );

  assign bus.stall  = stall;
  assign bus.busy   = (state != IDLE);
  assign bus.done   = (state == DONE);
  assign bus.result = result_q;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit in the EX stage, beside the integer ALU. It takes the same `funct3`/operand inputs that feed the ALU path when the ID/EX decode marks an instruction as M-extension (`funct7 = 0000001`). It runs one operation at a time over several cycles and asserts a stall to freeze IF/ID/EX until the result is ready. The result is muxed onto the EX result bus in the cycle `done` is high.

## Interface
- `XLEN`, default 32: operand/result width; also the iteration count.
- `clk`, in, 1: rising-edge clock.
- `rst`, in, 1: reset.
  - One clock; reset is synchronous and active-high.
- `start`, in, 1: EX holds an M-extension instruction; level, may stay high across cycles.
- `funct3`, in, 3: operation select.
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rs1`, in, XLEN: operand A; sampled only on an accepted start.
- `rs2`, in, XLEN: operand B; sampled only on an accepted start.
- `flush`, in, 1: abort the in-flight operation (branch/exception squash).
- `stall`, out, 1: freeze request to the pipeline registers.
- `busy`, out, 1: state ≠ IDLE.
- `done`, out, 1: one-cycle pulse; `result` is valid.
- `result`, out, XLEN: registered result, held until the next `done`.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE, when `start & ~flush`:
  - Latch `funct3`.
  - Latch operand magnitudes and sign flags. Signed operand for MUL/MULH/DIV/REM. For MULHSU only `rs1` is signed.
  - Load the counter with XLEN−1.
- IDLE → DONE directly for the special divide cases, with `result` loaded in the same edge:
  - Divisor zero: DIV/DIVU give all-ones; REM/REMU give `rs1`.
  - Signed overflow (DIV/REM, `rs1 = 0x80000000`, `rs2 = 0xFFFFFFFF`): DIV gives `0x80000000`, REM gives 0.
- IDLE → CALC otherwise.
- CALC, one iteration per cycle, counter decrements, → FIX when the counter is 0:
  - Multiply: shift-add on unsigned magnitudes into a 2·XLEN accumulator.
  - Divide: restoring division, shifting one quotient bit per cycle and keeping the XLEN+1-bit partial remainder.
- FIX: apply sign correction, select the output word, load `result`, → DONE.
  - Product is negated if the operand signs differ.
  - Quotient is negated if the signs differ; remainder takes the sign of the dividend.
  - MUL takes the low word. MULH/MULHSU/MULHU take the high word.
- DONE: `done` = 1 → IDLE unconditionally.
  - `start` is ignored in DONE, because the finished instruction is still in EX this cycle.
- `start` while busy (CALC/FIX) is ignored; operands are not re-sampled.
- `flush` in any state → IDLE next edge. `done` is never produced for the aborted operation and `result` is unchanged. `flush` beats `start` in the same cycle.
- `rst` (sync), any state, → IDLE next edge: `result` = 0, `done` = 0, counter = 0, sign flags = 0. Reset mid-operation discards the operation.

## Timing
- Cycle 0 = `start` sampled in IDLE.
- Normal path:
  - CALC cycles 1..XLEN (1..32), FIX cycle XLEN+1 (33), DONE cycle XLEN+2 (34).
  - `done` and `result` are valid in cycle 34; IDLE in cycle 35.
- Special-case path: DONE in cycle 1.
- `stall` = (IDLE & `start` & ~`flush`) | CALC | FIX.
  - It is combinational on `start` in IDLE. It is low in DONE so the pipeline advances at the end of the DONE cycle.
- `busy`, `done` and `result` are registered/state-decoded, with no combinational path from inputs.
- Reset values: `busy` 0, `done` 0, `result` 0, `stall` 0 (given `start` = 0).
- Back-to-back M instructions: the next `start` is accepted in cycle XLEN+3 at the earliest.

## Structure
- Shared package/header `rv32_pkg` holds:
  - funct3 codes (`F3_MUL`…`F3_REMU`) and `FUNCT7_MULDIV = 7'b0000001`.
  - State encodings (IDLE = 0, CALC = 1, FIX = 2, DONE = 3).
- One sub-module is natural: `muldiv_core`, holding the datapath (accumulator, partial remainder, per-iteration shift/add/subtract step).
  - It is driven by the FSM and counter in `muldiv_unit`.
  - It has no state of its own beyond the datapath registers.

## Test plan
- MUL `rs1` = 7, `rs2` = 0xFFFFFFFD → `stall` high in cycles 0–33; `done` only in cycle 34; `result` = 0xFFFFFFEB.
- High-word multiplies:
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- Divides:
  - DIV 0xFFFFFFF9 ÷ 2 → 0xFFFFFFFD.
  - REM same operands → 0xFFFFFFFF.
  - DIVU 7 ÷ 2 → 3.
  - REMU 7 ÷ 2 → 1.
- Special cases, each with `done` in cycle 1:
  - DIV 5 ÷ 0 → 0xFFFFFFFF.
  - REMU 5 ÷ 0 → 5.
  - DIV 0x80000000 ÷ 0xFFFFFFFF → 0x80000000.
  - REM same operands → 0.
- `start` held high through cycle 34 with `rs1` changed mid-run → exactly one `done` pulse and the original result. `flush` in cycle 10 → `busy` = 0 in cycle 11, no `done`, `result` unchanged.
- `rst` in cycle 20 of a DIVU → cycle 21: `busy` = 0, `done` = 0, `result` = 0. A new MUL 3 × 4 started afterwards → 12 in cycle 34 after its start.
